// File: rtl/tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tmr_scrub_ctrl
//  Brief    : Periodic scrub scheduler for selectively triplicated register
//             banks: scan, one-cycle voted reload, post-reload verify.
//  Revision : 1.0
// ============================================================================
module tmr_scrub_ctrl #(
    parameter int N_BANK = 4,
    parameter int PERIOD = 256,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sweep_req,
    input  logic [N_BANK-1:0] wr_req,
    output logic [N_BANK-1:0] wr_gnt,
    input  logic [N_BANK-1:0] mm,
    input  logic              clr_err,
    output logic [N_BANK-1:0] scrub_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [N_BANK-1:0] fatal
);

    localparam int                 c_IDX_W      = $clog2(N_BANK);
    localparam int                 c_TMR_W      = $clog2(PERIOD);
    localparam logic [c_TMR_W-1:0] c_TMR_RELOAD = c_TMR_W'(PERIOD - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(N_BANK - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_SCRUB  = 2'd2,
        ST_VERIFY = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_TMR_W-1:0]  r_timer;
    logic [N_BANK-1:0]   r_scrub_en;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [N_BANK-1:0]   r_fatal;

    logic                w_mm_cur;
    logic                w_wr_cur;
    logic                w_advance;
    logic [N_BANK-1:0]   w_idx_onehot;

    assign w_mm_cur     = mm[r_idx];
    assign w_wr_cur     = wr_req[r_idx];
    assign w_idx_onehot = {{(N_BANK-1){1'b0}}, 1'b1} << r_idx;

    // A bank is finished after a clean/write-covered scan or after its verify.
    assign w_advance = ((r_state == ST_SCAN) && (!w_mm_cur || w_wr_cur)) ||
                       (r_state == ST_VERIFY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_timer    <= c_TMR_RELOAD;
            r_scrub_en <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= '0;
            r_fatal    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_scrub_en <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end
                    if ((r_timer == '0) || sweep_req) begin
                        r_idx   <= '0;
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_mm_cur && !w_wr_cur) begin
                        if (r_err_cnt != c_CNT_MAX) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_scrub_en <= w_idx_onehot;
                        r_state    <= ST_SCRUB;
                    end
                end
                ST_SCRUB: begin
                    r_state <= ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (w_mm_cur) begin
                        r_fatal <= r_fatal | w_idx_onehot;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_advance) begin
                if (r_idx == c_LAST_IDX) begin
                    r_state <= ST_IDLE;
                    r_timer <= c_TMR_RELOAD;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_idx   <= r_idx + 1'b1;
                    r_state <= ST_SCAN;
                end
            end

            // Clear has the last word over any same-cycle increment or fatal set.
            if (clr_err) begin
                r_err_cnt <= '0;
                r_fatal   <= '0;
            end
        end
    end

    // A functional write in the scrub cycle owns the bank, so the reload is masked.
    assign scrub_en = r_scrub_en & ~wr_req;
    assign wr_gnt   = wr_req;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err_cnt  = r_err_cnt;
    assign fatal    = r_fatal;

endmodule
`default_nettype wire

// File: tb/tb_tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tmr_scrub_ctrl
//  Brief    : Scoreboard bench for tmr_scrub_ctrl with a simple bank model.
//  Revision : 1.0
// ============================================================================
module tb_tmr_scrub_ctrl;

    localparam int c_N      = 4;
    localparam int c_PERIOD = 8;
    localparam int c_CNT_W  = 2;

    logic             clk       = 1'b0;
    logic             rstn      = 1'b1;
    logic             sweep_req = 1'b0;
    logic             clr_err   = 1'b0;
    logic [c_N-1:0]   wr_req    = '0;
    logic [c_N-1:0]   stuck     = '0;
    logic [c_N-1:0]   inj_req   = '0;
    logic [c_N-1:0]   upset     = '0;
    logic [c_N-1:0]   wr_gnt;
    logic [c_N-1:0]   mm;
    logic [c_N-1:0]   scrub_en;
    logic [c_N-1:0]   fatal;
    logic             busy;
    logic             done;
    logic [c_CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int                 len;
        logic [c_N-1:0]     scrub;
        logic [c_CNT_W-1:0] err;
        logic [c_N-1:0]     fat;
    } exp_t;

    exp_t sb[$];

    tmr_scrub_ctrl #(
        .N_BANK (c_N),
        .PERIOD (c_PERIOD),
        .CNT_W  (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .sweep_req (sweep_req),
        .wr_req    (wr_req),
        .wr_gnt    (wr_gnt),
        .mm        (mm),
        .clr_err   (clr_err),
        .scrub_en  (scrub_en),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .fatal     (fatal)
    );

    always #5 clk = ~clk;

    // Bank model: transient upsets are healed by a scrub reload or a write.
    assign mm = upset | stuck;
    always @(posedge clk) upset <= (upset | inj_req) & ~(scrub_en | wr_gnt);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_sweep(input int len, input logic [c_N-1:0] s,
                                input logic [c_CNT_W-1:0] e, input logic [c_N-1:0] f);
        exp_t x;
        x.len = len; x.scrub = s; x.err = e; x.fat = f;
        sb.push_back(x);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_busy(output int n);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (busy) begin
                n = i;
                return;
            end
        end
        n = -1;
    endtask

    task automatic kick(input logic [c_N-1:0] inj);
        @(posedge clk); #1;
        sweep_req = 1'b1;
        inj_req   = inj;
        @(posedge clk); #1;
        sweep_req = 1'b0;
        inj_req   = '0;
    endtask

    // Sweep monitor: accumulates what it sees while busy, scores it on done.
    int             m_len   = 0;
    int             m_scnt  = 0;
    logic           m_multi = 1'b0;
    logic [c_N-1:0] m_scrub = '0;
    exp_t           m_e;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_len = 0; m_scnt = 0; m_multi = 1'b0; m_scrub = '0;
            end else begin
                if (busy) begin
                    m_len++;
                    m_scrub |= scrub_en;
                    if (scrub_en != '0) m_scnt++;
                    if ($countones(scrub_en) > 1) m_multi = 1'b1;
                end
                if (done) begin
                    check("busy_low_at_done", 32'(busy), 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        m_e = sb.pop_front();
                        check("sweep_len",    32'(m_len),   32'(m_e.len));
                        check("scrub_mask",   32'(m_scrub), 32'(m_e.scrub));
                        check("scrub_cycles", 32'(m_scnt),  32'($countones(m_e.scrub)));
                        check("scrub_onehot", 32'(m_multi), 32'd0);
                        check("err_cnt_end",  32'(err_cnt), 32'(m_e.err));
                        check("fatal_end",    32'(fatal),   32'(m_e.fat));
                    end
                    m_len = 0; m_scnt = 0; m_multi = 1'b0; m_scrub = '0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_scrub_en", 32'(scrub_en), 32'd0);
        check("rst_err_cnt",  32'(err_cnt),  32'd0);
        check("rst_fatal",    32'(fatal),    32'd0);

        // Idle timing with clean banks
        expect_sweep(4, 4'b0000, 2'd0, 4'b0000);
        expect_sweep(4, 4'b0000, 2'd0, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        wait_busy(n);
        check("first_sweep_delay", 32'(n), 32'd8);
        wait_done();
        wait_busy(n);
        check("period_after_done", 32'(n), 32'd8);
        wait_done();

        // Single transient upset in bank 2
        expect_sweep(6, 4'b0100, 2'd1, 4'b0000);
        kick(4'b0100);
        wait_done();

        // Stuck fault in bank 1; counter saturates at 3
        stuck = 4'b0010;
        expect_sweep(6, 4'b0010, 2'd2, 4'b0010);
        kick('0);
        wait_done();
        expect_sweep(6, 4'b0010, 2'd3, 4'b0010);
        kick('0);
        wait_done();
        expect_sweep(6, 4'b0010, 2'd3, 4'b0010);
        kick('0);
        wait_done();
        stuck = '0;
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_fatal",   32'(fatal),   32'd0);

        // Write during bank 3 SCAN skips the scrub
        expect_sweep(4, 4'b0000, 2'd0, 4'b0000);
        kick(4'b1000);
        repeat (3) @(posedge clk);
        #1 wr_req = 4'b1000;
        #1;
        check("wr_gnt_scan",      32'(wr_gnt),   32'h8);
        check("scrub_en_scan_wr", 32'(scrub_en), 32'd0);
        @(posedge clk); #1 wr_req = '0;
        wait_done();

        // Write during bank 3 SCRUB suppresses the reload
        expect_sweep(6, 4'b0000, 2'd1, 4'b0000);
        kick(4'b1000);
        repeat (4) @(posedge clk);
        #1 wr_req = 4'b1000;
        #1;
        check("wr_gnt_scrub",        32'(wr_gnt),   32'h8);
        check("scrub_en_suppressed", 32'(scrub_en), 32'd0);
        @(posedge clk); #1 wr_req = '0;
        wait_done();

        // All banks stuck; clear collides with bank 0 increment
        stuck = 4'b1111;
        expect_sweep(12, 4'b1111, 2'd3, 4'b1111);
        kick('0);
        clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        check("clr_collision_err", 32'(err_cnt), 32'd0);
        wait_done();
        stuck = '0;
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        check("clr2_err_cnt", 32'(err_cnt), 32'd0);
        check("clr2_fatal",   32'(fatal),   32'd0);

        // Asynchronous reset in the middle of a bank 0 scrub
        kick(4'b0001);
        @(posedge clk); #1;
        check("scrub_en_bank0", 32'(scrub_en), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("arst_scrub_en", 32'(scrub_en), 32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_err_cnt",  32'(err_cnt),  32'd0);
        expect_sweep(6, 4'b0001, 2'd1, 4'b0000);
        expect_sweep(4, 4'b0000, 2'd1, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        wait_busy(n);
        check("arst_restart_delay", 32'(n), 32'd8);
        @(posedge clk); #1 sweep_req = 1'b1;
        @(posedge clk); #1 sweep_req = 1'b0;
        wait_done();
        wait_busy(n);
        check("busy_req_dropped", 32'(n), 32'd8);
        wait_done();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Scrub scheduler for the banks of selectively triplicated registers. It periodically sweeps `N_BANK` register banks and inspects each bank's copy-mismatch flag. Mismatched banks get a one-cycle refresh, which reloads their voted value, and the controller then checks that the mismatch has cleared. Functional writes always have priority and are never stalled. The block sits beside the register banks, and its error outputs feed the status/interrupt logic.

## Interface
- `N_BANK`, 4: number of protected banks (2..16).
- `PERIOD`, 256: cycles from the end of one sweep to the start of the next (≥2).
- `CNT_W`, 8: width of the saturating error counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `sweep_req`  in  1  starts a sweep immediately if idle; ignored while busy.
- `wr_req`  in  N_BANK  functional write strobes, one per bank.
- `wr_gnt`  out  N_BANK  combinational, always equal to `wr_req`.
- `mm`  in  N_BANK  per-bank mismatch flag (some triplicated bit's copies disagree); combinational from the bank flops.
- `clr_err`  in  1  synchronous clear of `err_cnt` and `fatal`.
- `scrub_en`  out  N_BANK  registered load enable to bank: d=q reload of the voted value.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `err_cnt`  out  CNT_W  saturating count of mismatches detected.
- `fatal`  out  N_BANK  sticky; the bank is still mismatched after a scrub.

## Operation
- State machine: IDLE, SCAN, SCRUB, VERIFY. A bank index `idx` (0..N_BANK-1) and a down-counter `timer` support it.
- IDLE:
  - `timer` decrements each cycle.
  - If `timer`==0 or `sweep_req`, set `idx`=0 and go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - If `mm[idx]`=0, or `wr_req[idx]`=1, advance to the next bank. A functional write refreshes the bank, so the scrub is skipped and no error is counted.
  - Otherwise increment `err_cnt` (saturating at 2^CNT_W-1) and go to SCRUB.
- SCRUB:
  - `scrub_en[idx]`=1 for exactly this cycle.
  - If `wr_req[idx]`=1 in this cycle, force `scrub_en[idx]`=0. The write takes the bank.
  - Go to VERIFY.
- VERIFY: if `mm[idx]`=1, set `fatal[idx]`. Then advance to the next bank.
- Advance:
  - If `idx`<N_BANK-1, increment `idx` and go to SCAN.
  - Otherwise go to IDLE, reload `timer`=PERIOD-1 and pulse `done`.
- `clr_err` in any state:
  - Next cycle `err_cnt`=0 and `fatal`=0.
  - If an increment or `fatal` set happens in the same cycle, the clear wins.
- At most one bit of `scrub_en` is ever high.

## Timing
- Reset values: state=IDLE, `timer`=PERIOD-1, `idx`=0, `scrub_en`=0, `busy`=0, `done`=0, `err_cnt`=0, `fatal`=0.
- First automatic sweep starts PERIOD cycles after reset release.
- `busy` is registered: it is high from the first SCAN cycle through the last bank's final cycle. It is low in the cycle `done` is high.
- Cycles per bank: clean or write-skipped bank 1 (SCAN); mismatched bank 3 (SCAN, SCRUB, VERIFY).
  - Sweep of N_BANK clean banks: N_BANK cycles.
  - `done` asserts the cycle after the last bank's final state.
- `sweep_req` arriving in the same cycle that `timer` reaches 0 produces one sweep only. `timer` reloads only at sweep end.
- `sweep_req` while `busy` is dropped, not queued.
- If `rstn` asserts mid-sweep, all outputs return to reset values asynchronously; `scrub_en` drops immediately.
- `mm` is sampled in VERIFY, one cycle after `scrub_en`, when the reloaded flops are visible.

## Test plan
- Reset and idle, PERIOD=8, N_BANK=4, `mm`=0:
  - Expect `busy` high for 4 cycles starting 8 cycles after `rstn` rises, then a `done` pulse.
  - Next sweep starts 8 cycles after `done`; `err_cnt`=0.
- Single upset: `mm[2]`=1 until the `scrub_en[2]` edge.
  - Expect `scrub_en`=4'b0100 for one cycle.
  - Expect `err_cnt`=1, `fatal`=0, sweep length 6 cycles.
- Stuck fault: `mm[1]` held at 1.
  - Expect `fatal`=4'b0010 after VERIFY; `err_cnt` increments once per sweep.
  - `clr_err` returns both to 0.
- Write priority: `mm[3]`=1 and `wr_req[3]`=1 during bank 3's SCAN.
  - Expect no `scrub_en`, `err_cnt` unchanged, `wr_gnt[3]`=1 in the same cycle.
  - Repeat with `wr_req[3]` in SCRUB: `scrub_en[3]` suppressed.
- Saturation and clear collision, CNT_W=2, `mm` held at 4'b1111:
  - `err_cnt` stops at 3.
  - `clr_err` in a SCAN cycle with mismatch yields `err_cnt`=0.
- Async reset mid-SCRUB: assert `rstn`=0 while `scrub_en[0]`=1.
  - Expect `scrub_en`, `busy` and `err_cnt` at 0 before the next edge.
  - After release, the sweep restarts only after PERIOD cycles; `sweep_req` during the sweep is ignored.
